// File: rtl/cpu_pkg.sv
// Types and constants shared across the CPU front end.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_entry_t;

  localparam logic [31:0] INST_NOP = 32'h0;

endpackage : cpu_pkg

// File: rtl/fetch_inst_queue.sv
// Dual-issue instruction queue between fetch and the two decoders: up to two
// {pc, inst} pushes and two pops per cycle over a circular register store.
module fetch_inst_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_vld,
  input  logic [31:0]              push_pc0,
  input  logic [31:0]              push_pc1,
  input  logic [31:0]              push_inst0,
  input  logic [31:0]              push_inst1,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               head_vld,
  output logic [31:0]              head_pc0,
  output logic [31:0]              head_pc1,
  output logic [31:0]              head_inst0,
  output logic [31:0]              head_inst1,
  input  logic [1:0]               pop_num
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LIM = CW'(DEPTH - 2);

  inst_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0] wptr1_s, rptr1_s;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_push_s, n_pop_s, pop_req_s;
  logic          push_en_s, wr0_s, wr1_s;
  inst_entry_t   rd0_s, rd1_s;

  assign wptr1_s = wptr_q + AW'(1);
  assign rptr1_s = rptr_q + AW'(1);

  assign count    = count_q;
  assign full     = (count_q > FULL_LIM);
  assign empty    = (count_q == CW'(0));
  assign head_vld = {(count_q >= CW'(2)), (count_q != CW'(0))};

  // Push acceptance, pop clamping and next pointer/count state.
  always_comb begin
    push_en_s = 1'b0;
    wr0_s     = 1'b0;
    wr1_s     = 1'b0;
    n_push_s  = CW'(0);
    n_pop_s   = CW'(0);
    pop_req_s = {{(CW-2){1'b0}}, pop_num};
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;

    if (full || flush) begin
      push_en_s = 1'b0;
    end else begin
      push_en_s = 1'b1;
    end
    wr0_s    = push_en_s & push_vld[0];
    wr1_s    = push_en_s & push_vld[1];
    n_push_s = CW'(wr0_s) + CW'(wr1_s);

    // Over-popping is clamped to the occupancy so count never underflows.
    if (pop_req_s > count_q) begin
      n_pop_s = count_q;
    end else begin
      n_pop_s = pop_req_s;
    end

    if (flush) begin
      wptr_d  = AW'(0);
      rptr_d  = AW'(0);
      count_d = CW'(0);
    end else begin
      wptr_d  = wptr_q + n_push_s[AW-1:0];
      rptr_d  = rptr_q + n_pop_s[AW-1:0];
      count_d = count_q + n_push_s - n_pop_s;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= AW'(0);
      rptr_q  <= AW'(0);
      count_q <= CW'(0);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents survive reset and flush since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr0_s) begin
      mem_q[wptr_q] <= '{pc: push_pc0, inst: push_inst0};
    end
    if (wr1_s) begin
      mem_q[wptr1_s] <= '{pc: push_pc1, inst: push_inst1};
    end
  end

  assign rd0_s = mem_q[rptr_q];
  assign rd1_s = mem_q[rptr1_s];

  // Head slots, masked to NOP/zero PC when not valid.
  always_comb begin
    head_pc0   = 32'h0;
    head_inst0 = INST_NOP;
    head_pc1   = 32'h0;
    head_inst1 = INST_NOP;
    if (head_vld[0]) begin
      head_pc0   = rd0_s.pc;
      head_inst0 = rd0_s.inst;
    end else begin
      head_pc0   = 32'h0;
      head_inst0 = INST_NOP;
    end
    if (head_vld[1]) begin
      head_pc1   = rd1_s.pc;
      head_inst1 = rd1_s.inst;
    end else begin
      head_pc1   = 32'h0;
      head_inst1 = INST_NOP;
    end
  end

endmodule : fetch_inst_queue

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: directed pushes/pops, a reference
// entry queue checked by a negedge monitor, plus hand-computed status checks.
module tb_fetch_inst_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  push_vld, pop_num;
  logic [31:0] push_pc0, push_pc1, push_inst0, push_inst1;
  logic        full, empty;
  logic [4:0]  count;
  logic [1:0]  head_vld;
  logic [31:0] head_pc0, head_pc1, head_inst0, head_inst1;

  int checks = 0;
  int failures = 0;
  int ign_cnt = 0;
  inst_entry_t exp_q[$];

  fetch_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_vld(push_vld),
    .push_pc0(push_pc0), .push_pc1(push_pc1),
    .push_inst0(push_inst0), .push_inst1(push_inst1),
    .full(full), .empty(empty), .count(count), .head_vld(head_vld),
    .head_pc0(head_pc0), .head_pc1(head_pc1),
    .head_inst0(head_inst0), .head_inst1(head_inst1),
    .pop_num(pop_num)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compares consumed head entries with the reference queue, then updates it.
  always @(negedge clk) begin
    int n;
    int sz;
    inst_entry_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      chk("mon_count", 64'(count), 64'(sz));
      chk("mon_full", 64'(full), 64'(sz > DEPTH - 2));
      if (flush) begin
        exp_q.delete();
      end else begin
        n = (int'(pop_num) > sz) ? sz : int'(pop_num);
        for (int i = 0; i < n; i++) begin
          e = exp_q.pop_front();
          chk(i == 0 ? "pop_pc0" : "pop_pc1", 64'(i == 0 ? head_pc0 : head_pc1), 64'(e.pc));
          chk(i == 0 ? "pop_inst0" : "pop_inst1", 64'(i == 0 ? head_inst0 : head_inst1), 64'(e.inst));
        end
        if (push_vld != 2'b00) begin
          if (sz > DEPTH - 2) begin
            ign_cnt++;
          end else begin
            if (push_vld[0]) exp_q.push_back('{pc: push_pc0, inst: push_inst0});
            if (push_vld[1]) exp_q.push_back('{pc: push_pc1, inst: push_inst1});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    push_vld = 2'b00;
    pop_num  = 2'd0;
  endtask

  task automatic drive(input logic [1:0] vld, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] pop);
    push_vld   = vld;
    push_pc0   = pc0;
    push_inst0 = pc0 ^ 32'h5A5A_0000;
    push_pc1   = pc1;
    push_inst1 = pc1 ^ 32'h5A5A_0000;
    pop_num    = pop;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc, exp_pc;
    rst = 1'b1; flush = 1'b0; push_vld = 2'b00; pop_num = 2'd0;
    push_pc0 = 32'h0; push_pc1 = 32'h0; push_inst0 = 32'h0; push_inst1 = 32'h0;
    step(); step();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_head_vld", 64'(head_vld), 64'(0));
      chk("rst_head_inst0", 64'(head_inst0), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      step();
    end

    // Basic pair push and single pop
    push_vld = 2'b11; pop_num = 2'd0;
    push_pc0 = 32'hBFC00000; push_inst0 = 32'h24020001;
    push_pc1 = 32'hBFC00004; push_inst1 = 32'h24030002;
    step();
    chk("pair_head_vld", 64'(head_vld), 64'(2'b11));
    chk("pair_pc0", 64'(head_pc0), 64'h0BFC00000);
    chk("pair_inst0", 64'(head_inst0), 64'h24020001);
    chk("pair_pc1", 64'(head_pc1), 64'h0BFC00004);
    chk("pair_inst1", 64'(head_inst1), 64'h24030002);
    chk("pair_count", 64'(count), 64'(2));
    pop_num = 2'd1;
    step();
    chk("pop1_pc0", 64'(head_pc0), 64'h0BFC00004);
    chk("pop1_head_vld", 64'(head_vld), 64'(2'b01));
    chk("pop1_head_inst1", 64'(head_inst1), 64'(0));
    pop_num = 2'd1;
    step();
    chk("drain_empty", 64'(empty), 64'(1));

    // Fill with eight double pushes
    pc = 32'h0000_1000;
    for (int k = 1; k <= 8; k++) begin
      drive(2'b11, pc, pc + 32'd4, 2'd0);
      pc = pc + 32'd8;
      step();
      chk("fill_count", 64'(count), 64'(2 * k));
      chk("fill_full", 64'(full), 64'(k == 8));
    end
    drive(2'b11, 32'hDEAD0000, 32'hDEAD0004, 2'd0);
    step();
    chk("ovf_count", 64'(count), 64'(16));
    chk("ovf_ign", 64'(ign_cnt), 64'(1));
    pop_num = 2'd2;
    step();
    chk("pop2_count", 64'(count), 64'(14));
    chk("pop2_full", 64'(full), 64'(0));
    drive(2'b11, pc, pc + 32'd4, 2'd2);
    pc = pc + 32'd8;
    step();
    chk("p2p2_count", 64'(count), 64'(14));
    for (int k = 0; k < 7; k++) begin
      pop_num = 2'd2;
      step();
    end
    chk("fill_drain_empty", 64'(empty), 64'(1));

    // Wrap-around with odd pointers so slot pairs straddle the boundary
    pc = 32'h0000_2000;
    exp_pc = pc;
    drive(2'b01, pc, 32'h0, 2'd0);
    pc = pc + 32'd4;
    step();
    drive(2'b11, pc, pc + 32'd4, 2'd0);
    pc = pc + 32'd8;
    step();
    chk("wrap_count3", 64'(count), 64'(3));
    for (int k = 0; k < 20; k++) begin
      chk("wrap_seq_pc0", 64'(head_pc0), 64'(exp_pc));
      chk("wrap_seq_pc1", 64'(head_pc1), 64'(exp_pc + 32'd4));
      exp_pc = exp_pc + 32'd8;
      drive(2'b11, pc, pc + 32'd4, 2'd2);
      pc = pc + 32'd8;
      step();
    end
    chk("wrap_count_hold", 64'(count), 64'(3));
    pop_num = 2'd2;
    step();
    chk("wrap_count1", 64'(count), 64'(1));
    pop_num = 2'd2;
    step();
    chk("overpop_count", 64'(count), 64'(0));
    chk("overpop_empty", 64'(empty), 64'(1));
    drive(2'b01, 32'h0000_3000, 32'h0, 2'd0);
    step();
    chk("overpop_rd_pc0", 64'(head_pc0), 64'h3000);
    chk("overpop_rd_inst0", 64'(head_inst0), 64'(32'h0000_3000 ^ 32'h5A5A_0000));
    pop_num = 2'd1;
    step();

    // Flush at count 6 with simultaneous push 2 / pop 1
    pc = 32'h0000_4000;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, pc, pc + 32'd4, 2'd0);
      pc = pc + 32'd8;
      step();
    end
    chk("pre_flush_count", 64'(count), 64'(6));
    drive(2'b11, pc, pc + 32'd4, 2'd1);
    flush = 1'b1;
    step();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_empty", 64'(empty), 64'(1));
    chk("flush_head_inst0", 64'(head_inst0), 64'(0));
    chk("flush_head_vld", 64'(head_vld), 64'(0));
    drive(2'b01, 32'h0000_5000, 32'h0, 2'd0);
    step();
    chk("post_flush_vld", 64'(head_vld), 64'(2'b01));
    chk("post_flush_pc0", 64'(head_pc0), 64'h5000);
    pop_num = 2'd1;
    step();

    // Mid-operation reset behaves like flush
    drive(2'b11, 32'h0000_6000, 32'h0000_6004, 2'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_pc0", 64'(head_pc0), 64'(0));
    step();

    chk("ign_total", 64'(ign_cnt), 64'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_inst_queue
